// File: rtl/tx_packet_assembler.sv
// Switch/button packet assembler: builds a header + payload packet from debounced
// load presses and offers it to the TX framer over a valid/ready handshake.
module tx_packet_assembler #(
  parameter  int MAX_BYTES   = 16,
  parameter  int SYNC_STAGES = 2,
  localparam int LEN_W       = $clog2(MAX_BYTES),
  localparam int PKT_W       = 8 + 8 * MAX_BYTES
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_n,
  input  logic [1:0]       mode,
  input  logic [7:0]       data,
  output logic [PKT_W-1:0] tx_packet,
  output logic             tx_valid,
  input  logic             tx_ready,
  output logic             test_mode,
  output logic [1:0]       flag_status,
  output logic [LEN_W:0]   byte_cnt,
  output logic             err,
  output logic             rst_out_n
);

  typedef enum logic [1:0] {
    S_EMPTY,
    S_HDR,
    S_FULL
  } state_t;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;
  logic                   ev;

  state_t           state_q, state_d, base_state;
  logic [PKT_W-1:0] pkt_q, pkt_d;
  logic [LEN_W:0]   cnt_q, cnt_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic             err_q, err_d;
  logic             test_q, test_d;
  logic             rst_out_q, rst_out_d;

  logic [LEN_W-1:0] hdr_len;
  logic [3:0]       hdr_nib;
  logic [7:0]       hdr_byte;
  logic [LEN_W:0]   n_bytes;

  // Button is asynchronous; the history flop turns a held press into one event.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '1;
      hist_q <= 1'b1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], load_n};
      hist_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign ev = hist_q & ~sync_q[SYNC_STAGES-1];

  // The switch nibble carries len; narrow instances truncate it, wide ones extend it.
  if (LEN_W >= 4) begin : g_len_wide
    assign hdr_len = LEN_W'(data[3:0]);
    assign hdr_nib = data[3:0];
  end else begin : g_len_narrow
    assign hdr_len = data[LEN_W-1:0];
    assign hdr_nib = 4'(data[LEN_W-1:0]);
  end

  assign hdr_byte = {data[7:4], hdr_nib};
  assign n_bytes  = {1'b0, len_q} + (LEN_W + 1)'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_EMPTY;
      pkt_q     <= '0;
      cnt_q     <= '0;
      len_q     <= '0;
      err_q     <= 1'b0;
      test_q    <= 1'b0;
      rst_out_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      pkt_q     <= pkt_d;
      cnt_q     <= cnt_d;
      len_q     <= len_d;
      err_q     <= err_d;
      test_q    <= test_d;
      rst_out_q <= rst_out_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pkt_d      = pkt_q;
    cnt_d      = cnt_q;
    len_d      = len_q;
    err_d      = err_q;
    test_d     = test_q;
    rst_out_d  = 1'b1;
    base_state = state_q;

    // An accept in the same cycle as a load is applied first.
    if (state_q == S_FULL && tx_ready) begin
      pkt_d      = '0;
      cnt_d      = '0;
      state_d    = S_EMPTY;
      base_state = S_EMPTY;
    end

    if (ev) begin
      case (mode)
        2'b00: begin
          pkt_d     = '0;
          cnt_d     = '0;
          err_d     = 1'b0;
          test_d    = 1'b0;
          state_d   = S_EMPTY;
          rst_out_d = 1'b0;
        end
        2'b01: begin
          if (base_state != S_FULL) begin
            pkt_d   = {hdr_byte, {(8 * MAX_BYTES){1'b0}}};
            cnt_d   = '0;
            len_d   = hdr_len;
            state_d = S_HDR;
          end else begin
            err_d = 1'b1;
          end
        end
        2'b10: begin
          if (base_state == S_HDR) begin
            for (int k = 0; k < MAX_BYTES; k++) begin
              if (cnt_q == (LEN_W + 1)'(k)) pkt_d[PKT_W-9-8*k -: 8] = data;
            end
            cnt_d = cnt_q + (LEN_W + 1)'(1);
            if (cnt_d == n_bytes) state_d = S_FULL;
          end else begin
            err_d = 1'b1;
          end
        end
        default: test_d = data[0];
      endcase
    end
  end

  assign tx_packet   = pkt_q;
  assign tx_valid    = (state_q == S_FULL);
  assign flag_status = {state_q != S_EMPTY, state_q == S_FULL};
  assign byte_cnt    = cnt_q;
  assign err         = err_q;
  assign test_mode   = test_q;
  assign rst_out_n   = rst_out_q;

endmodule

// File: tb/tb_tx_packet_assembler.sv
// Bench for tx_packet_assembler: 16-byte and 4-byte instances checked against a
// queue-based packet model driven by directed and random load presses.
module tb_tx_packet_assembler;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, load_n, tx_ready;
  logic [1:0] mode;
  logic [7:0] data;
  int         sel;
  int         checks = 0;
  int         failures = 0;

  logic ln16, ln4, rdy16, rdy4;
  assign ln16  = (sel == 0) ? load_n : 1'b1;
  assign ln4   = (sel == 1) ? load_n : 1'b1;
  assign rdy16 = (sel == 0) ? tx_ready : 1'b0;
  assign rdy4  = (sel == 1) ? tx_ready : 1'b0;

  logic [135:0] pkt16;
  logic [39:0]  pkt4;
  logic         valid16, valid4, test16, test4, err16, err4, ro16, ro4;
  logic [1:0]   flag16, flag4;
  logic [4:0]   cnt16;
  logic [2:0]   cnt4;

  tx_packet_assembler #(.MAX_BYTES(16), .SYNC_STAGES(2)) dut16 (
    .clk(clk), .rst_n(rst_n), .load_n(ln16), .mode(mode), .data(data),
    .tx_packet(pkt16), .tx_valid(valid16), .tx_ready(rdy16), .test_mode(test16),
    .flag_status(flag16), .byte_cnt(cnt16), .err(err16), .rst_out_n(ro16)
  );

  tx_packet_assembler #(.MAX_BYTES(4), .SYNC_STAGES(2)) dut4 (
    .clk(clk), .rst_n(rst_n), .load_n(ln4), .mode(mode), .data(data),
    .tx_packet(pkt4), .tx_valid(valid4), .tx_ready(rdy4), .test_mode(test4),
    .flag_status(flag4), .byte_cnt(cnt4), .err(err4), .rst_out_n(ro4)
  );

  logic [135:0] obs_pkt;
  logic         obs_valid, obs_test, obs_err, obs_ro;
  logic [1:0]   obs_flag;
  int           obs_cnt;

  always_comb begin
    if (sel == 0) begin
      obs_pkt = pkt16; obs_valid = valid16; obs_test = test16; obs_err = err16;
      obs_ro = ro16; obs_flag = flag16; obs_cnt = int'(cnt16);
    end else begin
      obs_pkt = 136'(pkt4); obs_valid = valid4; obs_test = test4; obs_err = err4;
      obs_ro = ro4; obs_flag = flag4; obs_cnt = int'(cnt4);
    end
  end

  // Reference model: header byte plus a queue of stored payload bytes.
  int         mb;
  bit         m_hdr, m_err, m_test;
  logic [7:0] m_hbyte;
  int         m_n;
  logic [7:0] m_bytes[$];

  function automatic bit m_full();
    return m_hdr && (m_bytes.size() == m_n);
  endfunction

  function automatic void m_reset();
    m_hdr = 0; m_bytes.delete(); m_err = 0; m_test = 0; m_n = 0; m_hbyte = 8'h00;
  endfunction

  function automatic void m_event(input logic [1:0] md, input logic [7:0] d);
    int len;
    case (md)
      2'b00: begin m_hdr = 0; m_bytes.delete(); m_err = 0; m_test = 0; end
      2'b01: begin
        if (m_full()) m_err = 1;
        else begin
          len = int'(d[3:0]) % mb;
          m_hdr = 1; m_hbyte = {d[7:4], 4'(len)}; m_n = len + 1; m_bytes.delete();
        end
      end
      2'b10: begin
        if (m_hdr && !m_full()) m_bytes.push_back(d);
        else m_err = 1;
      end
      default: m_test = d[0];
    endcase
  endfunction

  function automatic void m_accept();
    if (m_full()) begin m_hdr = 0; m_bytes.delete(); end
  endfunction

  function automatic logic [135:0] m_pkt();
    logic [135:0] p;
    p = '0;
    if (m_hdr) begin
      p = 136'(m_hbyte) << (8 * mb);
      for (int k = 0; k < m_bytes.size(); k++) p = p | (136'(m_bytes[k]) << (8 * (mb - 1 - k)));
    end
    return p;
  endfunction

  task automatic chk(input string tag, input logic [135:0] obs, input logic [135:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".pkt"},   obs_pkt, m_pkt());
    chk({tag, ".valid"}, 136'(obs_valid), 136'(m_full()));
    chk({tag, ".flag"},  136'(obs_flag), 136'({m_hdr, m_full()}));
    chk({tag, ".cnt"},   136'(obs_cnt), 136'(m_bytes.size()));
    chk({tag, ".err"},   136'(obs_err), 136'(m_err));
    chk({tag, ".test"},  136'(obs_test), 136'(m_test));
    chk({tag, ".rstout"}, 136'(obs_ro), 136'(1));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [1:0] md, input logic [7:0] d);
    mode = md; data = d; load_n = 1'b0;
    repeat (4) tick();
    m_event(md, d);
    load_n = 1'b1;
    repeat (4) tick();
    $display("press mode=%0d data=%02h cnt=%0d valid=%0b err=%0b", md, d, obs_cnt, obs_valid, obs_err);
  endtask

  task automatic accept();
    tx_ready = 1'b1;
    tick();
    m_accept();
    tx_ready = 1'b0;
  endtask

  initial begin
    logic [1:0] rmode;
    logic [7:0] rdata;
    int         r;

    sel = 0; mb = 16; rst_n = 1'b0; load_n = 1'b1; tx_ready = 1'b0; mode = 2'b00; data = 8'h00;
    m_reset();
    tick(); tick();
    check_all("reset");
    rst_n = 1'b1;
    tick();

    // Basic packet: header 0x93 then four payload bytes.
    press(2'b01, 8'h93);
    check_all("hdr");
    press(2'b10, 8'hA1);
    press(2'b10, 8'hB2);
    press(2'b10, 8'hC3);
    check_all("pay3");
    press(2'b10, 8'hD4);
    check_all("full");
    chk("tp_hi", 136'(obs_pkt[135:96]), 136'(40'h93A1B2C3D4));
    chk("tp_lo", 136'(obs_pkt[95:0]), 136'(0));

    // Stall, then illegal loads while FULL, then accept.
    repeat (20) tick();
    check_all("stall");
    press(2'b01, 8'h55);
    check_all("ill_hdr");
    press(2'b10, 8'h66);
    check_all("ill_pay");
    accept();
    check_all("accept");

    // Re-header restarts the packet and clears stale payload.
    press(2'b00, 8'h00);
    press(2'b01, 8'h01);
    press(2'b10, 8'h55);
    press(2'b01, 8'h00);
    press(2'b10, 8'h77);
    check_all("rehdr");
    chk("rehdr_b1", 136'(obs_pkt[119:112]), 136'(0));
    accept();

    // Held load: one event, visible at the third edge.
    press(2'b01, 8'h0F);
    mode = 2'b10; data = 8'hE5; load_n = 1'b0;
    tick(); chk("lat_e1", 136'(obs_cnt), 136'(0));
    tick(); chk("lat_e2", 136'(obs_cnt), 136'(0));
    tick(); m_event(2'b10, 8'hE5); check_all("lat_e3");
    repeat (47) tick();
    load_n = 1'b1;
    repeat (4) tick();
    check_all("held");

    // Test mode, clear pulse and asynchronous reset.
    press(2'b11, 8'h01);
    check_all("test1");
    mode = 2'b00; data = 8'h00; load_n = 1'b0;
    tick(); tick(); chk("ro_pre", 136'(obs_ro), 136'(1));
    tick(); chk("ro_low", 136'(obs_ro), 136'(0));
    m_event(2'b00, 8'h00);
    tick(); chk("ro_back", 136'(obs_ro), 136'(1));
    load_n = 1'b1;
    repeat (4) tick();
    check_all("cleared");
    press(2'b01, 8'h23);
    press(2'b10, 8'h11);
    #2 rst_n = 1'b0;
    #1 m_reset();
    check_all("async");
    tick();
    rst_n = 1'b1;
    tick();

    // Random loads and accepts.
    for (int i = 0; i < 40; i++) begin
      r = $urandom_range(0, 9);
      rmode = (r == 0) ? 2'b00 : (r <= 2) ? 2'b01 : (r == 3) ? 2'b11 : 2'b10;
      rdata = 8'($urandom);
      press(rmode, rdata);
      check_all("rnd");
      if (m_full() && ($urandom_range(0, 1) == 1)) begin
        accept();
        check_all("rnd_acc");
      end
    end

    // Four-byte instance.
    rst_n = 1'b0;
    tick();
    sel = 1; mb = 4; m_reset();
    rst_n = 1'b1;
    tick();
    check_all("m4_reset");
    press(2'b01, 8'h93);
    press(2'b10, 8'h11);
    press(2'b10, 8'h22);
    press(2'b10, 8'h33);
    press(2'b10, 8'h44);
    check_all("m4_full");
    chk("m4_tp", obs_pkt, 136'(40'h9311223344));

    // Payload event landing on the accept edge.
    mode = 2'b10; data = 8'hAB; load_n = 1'b0;
    tick(); tick();
    tx_ready = 1'b1;
    tick();
    m_accept();
    m_event(2'b10, 8'hAB);
    tx_ready = 1'b0;
    check_all("coinc");
    chk("coinc_err", 136'(obs_err), 136'(1));
    load_n = 1'b1;
    repeat (4) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
